// File: rtl/pll_reconfig_ctrl.sv
// Reset/lock sequencer for a dynamically reconfigurable Gowin rPLL.
// Qualifies LOCK, retries on timeout, and applies divider changes only while the PLL is held in reset.
module pll_reconfig_ctrl #(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_FILTER  = 64,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned MAX_RETRY    = 3,
    parameter logic [5:0]  DEF_IDSEL    = 6'd62,
    parameter logic [5:0]  DEF_FBDSEL   = 6'd60,
    parameter logic [5:0]  DEF_ODSEL    = 6'd60
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [5:0]                         req_idsel,
    input  logic [5:0]                         req_fbdsel,
    input  logic [5:0]                         req_odsel,
    output logic                               pll_reset,
    output logic [5:0]                         pll_idsel,
    output logic [5:0]                         pll_fbdsel,
    output logic [5:0]                         pll_odsel,
    input  logic                               pll_lock,
    output logic                               locked,
    output logic                               sys_rstn,
    output logic                               fail,
    output logic                               lost_lock,
    output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt
);

    localparam int unsigned RCW = $clog2(RESET_CYCLES + 1);
    localparam int unsigned FCW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
    localparam int unsigned TCW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int unsigned RW  = $clog2(MAX_RETRY + 1);

    localparam logic [FCW-1:0] FILT_MAX = FCW'(LOCK_FILTER - 1);
    localparam logic [TCW-1:0] TO_MAX   = TCW'(LOCK_TIMEOUT - 1);

    typedef enum logic [1:0] {RESET_HOLD, WAIT_LOCK, LOCKED, FAIL} state_t;

    state_t         state, next_state;
    logic           lock_m, lock_s;
    logic [RCW-1:0] rst_cnt;
    logic [FCW-1:0] filt_cnt;
    logic [TCW-1:0] to_cnt;
    logic           pll_reset_q, locked_q, fail_q;
    logic           accept, lock_ok, timeout, lock_loss, can_retry;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= RESET_HOLD;
        else         state <= next_state;
    end

    always_comb begin
        accept    = req_valid && req_ready;
        lock_ok   = lock_s && (filt_cnt == FILT_MAX);
        timeout   = (to_cnt == TO_MAX);
        lock_loss = (state == LOCKED) && !lock_s;
        can_retry = (retry_cnt < RW'(MAX_RETRY));
    end

    always_comb begin
        next_state = state;
        unique case (state)
            RESET_HOLD: if (rst_cnt == RCW'(1)) next_state = WAIT_LOCK;
            WAIT_LOCK: begin
                // a qualifying lock beats a same-cycle timeout
                if (lock_ok)      next_state = LOCKED;
                else if (timeout) next_state = can_retry ? RESET_HOLD : FAIL;
            end
            LOCKED:     if (accept || !lock_s) next_state = RESET_HOLD;
            FAIL:       if (accept) next_state = RESET_HOLD;
        endcase
    end

    always_comb begin
        req_ready = (state == LOCKED) || (state == FAIL);
        pll_reset = pll_reset_q;
        locked    = locked_q;
        sys_rstn  = locked_q;
        fail      = fail_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_cnt     <= RCW'(RESET_CYCLES);
            filt_cnt    <= '0;
            to_cnt      <= '0;
            retry_cnt   <= '0;
            lost_lock   <= 1'b0;
            pll_idsel   <= DEF_IDSEL;
            pll_fbdsel  <= DEF_FBDSEL;
            pll_odsel   <= DEF_ODSEL;
            pll_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            // counters are preloaded/cleared whenever their state is inactive
            if (state == RESET_HOLD) begin
                if (rst_cnt != '0) rst_cnt <= rst_cnt - 1'b1;
            end else begin
                rst_cnt <= RCW'(RESET_CYCLES);
            end

            if (state == WAIT_LOCK) begin
                if (!lock_s)                filt_cnt <= '0;
                else if (filt_cnt != FILT_MAX) filt_cnt <= filt_cnt + 1'b1;
                if (to_cnt != TO_MAX)       to_cnt <= to_cnt + 1'b1;
            end else begin
                filt_cnt <= '0;
                to_cnt   <= '0;
            end

            if (accept) begin
                pll_idsel  <= req_idsel;
                pll_fbdsel <= req_fbdsel;
                pll_odsel  <= req_odsel;
                retry_cnt  <= '0;
            end else if (lock_loss) begin
                retry_cnt  <= '0;
            end else if (state == WAIT_LOCK && !lock_ok && timeout && can_retry) begin
                retry_cnt  <= retry_cnt + 1'b1;
            end

            if (accept)         lost_lock <= lock_loss;
            else if (lock_loss) lost_lock <= 1'b1;

            pll_reset_q <= (next_state == RESET_HOLD);
            locked_q    <= (next_state == LOCKED);
            fail_q      <= (next_state == FAIL);
        end
    end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl: directed vector table, corner sequences,
// and randomized traffic against an event-level reference model.
module tb_pll_reconfig_ctrl;

    localparam int unsigned RC = 4;
    localparam int unsigned LF = 8;
    localparam int unsigned LT = 100;
    localparam int unsigned MR = 3;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [5:0] req_idsel = '0, req_fbdsel = '0, req_odsel = '0;
    logic       pll_reset;
    logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
    logic       pll_lock = 1'b0;
    logic       locked, sys_rstn, fail, lost_lock;
    logic [1:0] retry_cnt;

    always #5 clk = ~clk;

    pll_reconfig_ctrl #(
        .RESET_CYCLES (RC),
        .LOCK_FILTER  (LF),
        .LOCK_TIMEOUT (LT),
        .MAX_RETRY    (MR)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_idsel  (req_idsel),
        .req_fbdsel (req_fbdsel),
        .req_odsel  (req_odsel),
        .pll_reset  (pll_reset),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .pll_lock   (pll_lock),
        .locked     (locked),
        .sys_rstn   (sys_rstn),
        .fail       (fail),
        .lost_lock  (lost_lock),
        .retry_cnt  (retry_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase flags plus elapsed-cycle counts, updated once per clock edge.
    bit         m_hold, m_wait, m_lk, m_fl, m_lost, m_lm, m_ls;
    int         m_hold_left, m_run, m_waited, m_retries;
    logic [5:0] m_id, m_fb, m_od;

    typedef struct {
        int         n;
        bit         lock, valid;
        logic [5:0] id, fb, od;
        bit         rst, lk, fl, rdy, lost;
        logic [1:0] retry;
        logic [5:0] eid, efb, eod;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] dut_vec();
        return {6'b0, pll_reset, locked, sys_rstn, fail, req_ready, lost_lock, retry_cnt,
                pll_idsel, pll_fbdsel, pll_odsel};
    endfunction

    function automatic logic [31:0] pack(input bit rst, lk, fl, rdy, lost, input logic [1:0] retry,
                                         input logic [5:0] id, fb, od);
        return {6'b0, rst, lk, lk, fl, rdy, lost, retry, id, fb, od};
    endfunction

    function automatic logic [31:0] model_vec();
        return pack(m_hold, m_lk, m_fl, m_lk | m_fl, m_lost, 2'(m_retries), m_id, m_fb, m_od);
    endfunction

    function automatic vec_t mk(input int n, input bit lock, valid, input logic [5:0] id, fb, od,
                                input bit rst, lk, fl, rdy, lost, input logic [1:0] retry,
                                input logic [5:0] eid, efb, eod);
        vec_t v;
        v.n = n; v.lock = lock; v.valid = valid; v.id = id; v.fb = fb; v.od = od;
        v.rst = rst; v.lk = lk; v.fl = fl; v.rdy = rdy; v.lost = lost; v.retry = retry;
        v.eid = eid; v.efb = efb; v.eod = eod;
        return v;
    endfunction

    task automatic start_hold();
        m_hold = 1'b1; m_hold_left = RC; m_lk = 1'b0; m_wait = 1'b0;
    endtask

    task automatic model_reset();
        m_lk = 1'b0; m_fl = 1'b0; m_lost = 1'b0; m_lm = 1'b0; m_ls = 1'b0;
        m_retries = 0; m_run = 0; m_waited = 0;
        m_id = 6'd62; m_fb = 6'd60; m_od = 6'd60;
        start_hold();
    endtask

    task automatic model_step();
        bit ls, acc, loss;
        ls   = m_ls;
        acc  = req_valid && (m_lk || m_fl);
        loss = m_lk && !ls;
        if (acc) begin
            m_id = req_idsel; m_fb = req_fbdsel; m_od = req_odsel;
            m_retries = 0; m_fl = 1'b0; m_lost = loss;
            start_hold();
        end else if (m_hold) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                m_hold = 1'b0; m_wait = 1'b1; m_run = 0; m_waited = 0;
            end
        end else if (m_wait) begin
            m_run = ls ? m_run + 1 : 0;
            m_waited++;
            if (m_run == LF) begin
                m_wait = 1'b0; m_lk = 1'b1;
            end else if (m_waited == LT) begin
                m_wait = 1'b0;
                if (m_retries < MR) begin
                    m_retries++;
                    start_hold();
                end else begin
                    m_fl = 1'b1;
                end
            end
        end else if (loss) begin
            m_lost = 1'b1; m_retries = 0;
            start_hold();
        end
        m_ls = m_lm;
        m_lm = pll_lock;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model", dut_vec(), model_vec());
    endtask

    initial begin
        int  cycles, pulses;
        bit  prev, mono;
        logic [1:0] last_retry;

        // columns: cycles, lock, valid, req codes | pll_reset, locked, fail, ready, lost, retry, codes
        tbl.push_back(mk(3,  1'b0, 1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd62, 6'd60, 6'd60));
        tbl.push_back(mk(1,  1'b0, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd62, 6'd60, 6'd60));
        tbl.push_back(mk(19, 1'b0, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd62, 6'd60, 6'd60));
        tbl.push_back(mk(9,  1'b1, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd62, 6'd60, 6'd60));
        tbl.push_back(mk(1,  1'b1, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 6'd62, 6'd60, 6'd60));
        tbl.push_back(mk(1,  1'b1, 1'b1, 6'd61, 6'd59, 6'd58, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd61, 6'd59, 6'd58));
        tbl.push_back(mk(3,  1'b1, 1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd61, 6'd59, 6'd58));
        tbl.push_back(mk(1,  1'b1, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd61, 6'd59, 6'd58));
        tbl.push_back(mk(7,  1'b1, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd61, 6'd59, 6'd58));
        tbl.push_back(mk(1,  1'b1, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 6'd61, 6'd59, 6'd58));
        tbl.push_back(mk(1,  1'b0, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 6'd61, 6'd59, 6'd58));
        tbl.push_back(mk(1,  1'b1, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 6'd61, 6'd59, 6'd58));
        tbl.push_back(mk(1,  1'b1, 1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'd61, 6'd59, 6'd58));
        tbl.push_back(mk(3,  1'b1, 1'b0, 6'd0,  6'd0,  6'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'd61, 6'd59, 6'd58));
        tbl.push_back(mk(1,  1'b1, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'd61, 6'd59, 6'd58));
        tbl.push_back(mk(7,  1'b1, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 6'd61, 6'd59, 6'd58));
        tbl.push_back(mk(1,  1'b1, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0, 6'd61, 6'd59, 6'd58));
        tbl.push_back(mk(1,  1'b1, 1'b1, 6'd62, 6'd60, 6'd60, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd62, 6'd60, 6'd60));
        tbl.push_back(mk(12, 1'b1, 1'b0, 6'd0,  6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 6'd62, 6'd60, 6'd60));

        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_values", dut_vec(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd62, 6'd60, 6'd60));
        model_reset();
        resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            pll_lock   = tbl[i].lock;
            req_valid  = tbl[i].valid;
            req_idsel  = tbl[i].id;
            req_fbdsel = tbl[i].fb;
            req_odsel  = tbl[i].od;
            repeat (tbl[i].n) tick();
            check($sformatf("vec%0d", i), dut_vec(),
                  pack(tbl[i].rst, tbl[i].lk, tbl[i].fl, tbl[i].rdy, tbl[i].lost, tbl[i].retry,
                       tbl[i].eid, tbl[i].efb, tbl[i].eod));
        end
        req_valid = 1'b0;

        // lock glitch during WAIT_LOCK restarts the filter
        pll_lock = 1'b0; req_valid = 1'b1;
        req_idsel = 6'd61; req_fbdsel = 6'd59; req_odsel = 6'd58;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        check("glitch_wait", 32'(pll_reset), 32'd0);
        pll_lock = 1'b1;
        repeat (5) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("glitch_lock", 32'(locked), 32'(i == 10));
        end

        // permanent lock absence: retries then FAIL
        pll_lock = 1'b0; req_valid = 1'b1;
        req_idsel = 6'd62; req_fbdsel = 6'd60; req_odsel = 6'd60;
        tick();
        req_valid = 1'b0;
        pulses = 1;
        repeat (4) tick();
        check("fail_wait_start", 32'(pll_reset), 32'd0);
        prev = pll_reset; mono = 1'b1; last_retry = retry_cnt; cycles = 0;
        while (!fail && cycles < 1000) begin
            tick();
            cycles++;
            if (pll_reset && !prev) pulses++;
            prev = pll_reset;
            if (retry_cnt < last_retry) mono = 1'b0;
            last_retry = retry_cnt;
        end
        check("fail_time", 32'(cycles), 32'(4 * LT + 3 * RC));
        check("fail_pulses", 32'(pulses), 32'd4);
        check("fail_retry", 32'(retry_cnt), 32'd3);
        check("fail_retry_steps", 32'(mono), 32'd1);
        check("fail_ready", 32'(req_ready), 32'd1);

        // request out of FAIL
        pll_lock = 1'b1; req_valid = 1'b1;
        req_idsel = 6'd61; req_fbdsel = 6'd59; req_odsel = 6'd58;
        tick();
        req_valid = 1'b0;
        check("fail_exit", dut_vec(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd61, 6'd59, 6'd58));
        repeat (12) tick();
        check("fail_relock", dut_vec(), pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 6'd61, 6'd59, 6'd58));

        // asynchronous reset in the middle of WAIT_LOCK
        req_valid = 1'b1; req_idsel = 6'd33; req_fbdsel = 6'd34; req_odsel = 6'd35;
        tick();
        req_valid = 1'b0;
        repeat (6) tick();
        #2 resetn = 1'b0;
        #1 check("async_reset", dut_vec(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 6'd62, 6'd60, 6'd60));
        model_reset();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (12) tick();
        check("reset_relock", dut_vec(), pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 6'd62, 6'd60, 6'd60));

        // randomized traffic; every third 500-cycle window keeps the PLL unlocked
        for (int i = 0; i < 3000; i++) begin
            if (((i / 500) % 3) == 2) pll_lock = 1'b0;
            else if ($urandom_range(0, 39) == 0) pll_lock = ~pll_lock;
            req_valid  = ($urandom_range(0, 29) == 0);
            req_idsel  = 6'($urandom);
            req_fbdsel = 6'($urandom);
            req_odsel  = 6'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
